// File: rtl/nearest_sample_finder_pkg.sv
// Shared types and width helpers for the nearest-sample finder.
package nnf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Accumulator width: d squared N-bit differences summed without wrap.
    function automatic int unsigned dist_w(input int unsigned n, input int unsigned dims);
        return 2 * n + $clog2(dims) + 1;
    endfunction

endpackage

// File: rtl/nearest_sample_finder_if.sv
// Memory read port, search control and result bus of the nearest-sample finder.
interface nearest_sample_finder_if #(
    parameter int unsigned Q = 8,
    parameter int unsigned d = 4,
    parameter int unsigned N = 8
);
    import nnf_pkg::*;

    localparam int unsigned DIST_W = dist_w(N, d);

    logic              start;
    logic [d*N-1:0]    query;
    logic              memRead;
    logic [Q-1:0]      addr;
    logic [d-1:0]      index_dimension;
    logic [N-1:0]      mem_data;
    logic              busy;
    logic              done;
    logic [Q-1:0]      best_addr;
    logic [DIST_W-1:0] best_dist;

    modport master (
        output start, query, mem_data,
        input  memRead, addr, index_dimension, busy, done, best_addr, best_dist
    );

    modport slave (
        input  start, query, mem_data,
        output memRead, addr, index_dimension, busy, done, best_addr, best_dist
    );

endinterface

// File: rtl/nearest_sample_finder_sq_diff.sv
// Squared absolute difference of two unsigned N-bit values.
module sq_diff #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] sq_o
);
    logic [N-1:0] diff;

    always_comb begin
        diff = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
        sq_o = (2*N)'(diff) * (2*N)'(diff);
    end

endmodule

// File: rtl/nearest_sample_finder.sv
// Walks all samples in memory and reports the one nearest to a latched query vector.
// Define NNF_EARLY_ABORT_EN to drop a sample as soon as its partial distance cannot win.
module nearest_sample_finder #(
    parameter int unsigned Q = 8,
    parameter int unsigned d = 4,
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    nearest_sample_finder_if.slave bus
);
    import nnf_pkg::*;

    localparam int unsigned  DIST_W    = dist_w(N, d);
    localparam logic [Q-1:0] ADDR_LAST = Q'(Q - 1);
    localparam logic [d-1:0] DIM_LAST  = d'(d - 1);

    state_t              state_q, state_d;
    logic [Q-1:0]        addr_q, addr_d;
    logic [d-1:0]        dim_q, dim_d;
    logic [d-1:0]        dim_prev_q;
    logic [d*N-1:0]      query_q, query_d;
    logic [DIST_W-1:0]   acc_q, acc_d;
    logic [DIST_W-1:0]   best_q, best_d;
    logic [Q-1:0]        best_idx_q, best_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [Q-1:0]        best_addr_q, best_addr_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;

    logic [N-1:0]        q_sel;
    logic [2*N-1:0]      sq;
    logic [DIST_W-1:0]   acc_sum;
`ifdef NNF_EARLY_ABORT_EN
    logic                abort_c;
`endif

    // mem_data always belongs to the dimension issued one cycle earlier
    assign q_sel   = query_q[32'(dim_prev_q) * N +: N];
    assign acc_sum = acc_q + DIST_W'(sq);

    sq_diff #(.N(N)) u_sq_diff (
        .a_i  (bus.mem_data),
        .b_i  (q_sel),
        .sq_o (sq)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dim_d       = dim_q;
        query_d     = query_q;
        acc_d       = acc_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        best_addr_d = best_addr_q;
        best_dist_d = best_dist_q;
`ifdef NNF_EARLY_ABORT_EN
        abort_c     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // busy still covers the done cycle, so a held start is not re-accepted there
                if (bus.start && !busy_q) begin
                    state_d    = READ;
                    addr_d     = '0;
                    dim_d      = '0;
                    query_d    = bus.query;
                    acc_d      = '0;
                    best_d     = '1;
                    best_idx_d = '0;
                    busy_d     = 1'b1;
                end
            end
            READ: begin
                if (dim_q != '0) acc_d = acc_sum;
                if (dim_q == DIM_LAST) state_d = CMP;
                else                   dim_d   = dim_q + d'(1);
`ifdef NNF_EARLY_ABORT_EN
                if (dim_q != '0 && addr_q != '0 && acc_sum >= best_q) begin
                    abort_c = 1'b1;
                    acc_d   = '0;
                    dim_d   = '0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        addr_d  = addr_q + Q'(1);
                    end
                end
`endif
            end
            CMP: begin
                if (acc_sum < best_q) begin
                    best_d     = acc_sum;
                    best_idx_d = addr_q;
                end
                acc_d = '0;
                dim_d = '0;
                if (addr_q == ADDR_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                    addr_d  = addr_q + Q'(1);
                end
            end
            DONE: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                best_addr_d = best_idx_q;
                best_dist_d = best_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            dim_q       <= '0;
            dim_prev_q  <= '0;
            query_q     <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            best_addr_q <= '0;
            best_dist_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dim_q       <= dim_d;
            dim_prev_q  <= dim_q;
            query_q     <= query_d;
            acc_q       <= acc_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            best_addr_q <= best_addr_d;
            best_dist_q <= best_dist_d;
        end
    end

`ifdef NNF_EARLY_ABORT_EN
    assign bus.memRead = (state_q == READ) && !abort_c;
`else
    assign bus.memRead = (state_q == READ);
`endif
    assign bus.addr            = addr_q;
    assign bus.index_dimension = dim_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.best_addr       = best_addr_q;
    assign bus.best_dist       = best_dist_q;

endmodule

// File: tb/tb_nearest_sample_finder.sv
// Self-checking bench for nearest_sample_finder (Q=4, d=2, N=4) with a 1-cycle memory model.
module tb_nearest_sample_finder;

    localparam int Q  = 4;
    localparam int D  = 2;
    localparam int NB = 4;
    localparam int FIXED_LAT = Q * (D + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nearest_sample_finder_if #(.Q(Q), .d(D), .N(NB)) bus ();

    nearest_sample_finder #(.Q(Q), .d(D), .N(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NB-1:0] mem [Q][D];
    logic [NB-1:0] qv  [D];
    int            rd_total = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Memory with one cycle of read latency; counts issued reads
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_data <= '0;
        end else if (bus.memRead === 1'b1) begin
            bus.mem_data <= mem[bus.addr[1:0]][bus.index_dimension[0]];
            rd_total     <= rd_total + 1;
        end
    end

    // Reference: brute-force squared Euclidean distance, strict < keeps the lowest index
    function automatic void model(output int ba, output int bd);
        ba = 0;
        bd = -1;
        for (int i = 0; i < Q; i++) begin
            int s;
            s = 0;
            for (int j = 0; j < D; j++) begin
                int df;
                df = int'(mem[i][j]) - int'(qv[j]);
                s += df * df;
            end
            if (bd < 0 || s < bd) begin
                bd = s;
                ba = i;
            end
        end
    endfunction

    task automatic set_sample(input int i, input int a, input int b);
        mem[i][0] = NB'(a);
        mem[i][1] = NB'(b);
    endtask

    task automatic set_query(input int a, input int b);
        qv[0] = NB'(a);
        qv[1] = NB'(b);
    endtask

    task automatic do_search(input bit hold, output int lat, output int ndone, output int reads,
                             output logic busy_first, output logic busy_at_done);
        int r0;
        @(negedge clk);
        for (int j = 0; j < D; j++) bus.query[j*NB +: NB] = qv[j];
        bus.start = 1'b1;
        r0 = rd_total;
        @(posedge clk);
        #1;
        busy_first   = bus.busy;
        busy_at_done = 1'b0;
        lat          = -1;
        ndone        = 0;
        if (!hold) bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat          = k;
                    busy_at_done = bus.busy;
                end
                bus.start = 1'b0;
            end
        end
        reads = rd_total - r0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #7;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.memRead !== 1'b0) begin n_fail++; $display("FAIL reset_memRead: got %b expected 0", bus.memRead); end
        n_checks++; if (bus.best_addr !== '0) begin n_fail++; $display("FAIL reset_best_addr: got %0d expected 0", bus.best_addr); end
        n_checks++; if (bus.best_dist !== '0) begin n_fail++; $display("FAIL reset_best_dist: got %0d expected 0", bus.best_dist); end
    endtask

    task automatic test_example();
        int lat, nd, rd, ba, bd;
        logic bf, bdn;
        set_sample(0, 1, 1); set_sample(1, 5, 5); set_sample(2, 9, 2); set_sample(3, 3, 3);
        set_query(3, 3);
        model(ba, bd);
        do_search(1'b0, lat, nd, rd, bf, bdn);
        n_checks++; if (bus.best_addr !== 4'd3 || ba != 3) begin n_fail++; $display("FAIL example_addr: got %0d expected 3", bus.best_addr); end
        n_checks++; if (bus.best_dist !== 10'd0 || bd != 0) begin n_fail++; $display("FAIL example_dist: got %0d expected 0", bus.best_dist); end
        n_checks++; if (bf !== 1'b1) begin n_fail++; $display("FAIL example_busy_start: got %b expected 1", bf); end
        n_checks++; if (bdn !== 1'b1) begin n_fail++; $display("FAIL example_busy_done: got %b expected 1", bdn); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL example_done_pulses: got %0d expected 1", nd); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL example_busy_after: got %b expected 0", bus.busy); end
`ifndef NNF_EARLY_ABORT_EN
        n_checks++; if (lat != FIXED_LAT) begin n_fail++; $display("FAIL example_latency: got %0d expected %0d", lat, FIXED_LAT); end
        n_checks++; if (rd != Q * D) begin n_fail++; $display("FAIL example_reads: got %0d expected %0d", rd, Q * D); end
`else
        n_checks++; if (lat < 1 || lat > FIXED_LAT) begin n_fail++; $display("FAIL example_latency: got %0d expected 1..%0d", lat, FIXED_LAT); end
`endif
    endtask

    task automatic test_tie();
        int lat, nd, rd;
        logic bf, bdn;
        set_sample(0, 2, 2); set_sample(1, 4, 4); set_sample(2, 0, 0); set_sample(3, 6, 6);
        set_query(3, 3);
        do_search(1'b0, lat, nd, rd, bf, bdn);
        n_checks++; if (bus.best_addr !== 4'd0) begin n_fail++; $display("FAIL tie_addr: got %0d expected 0", bus.best_addr); end
        n_checks++; if (bus.best_dist !== 10'd2) begin n_fail++; $display("FAIL tie_dist: got %0d expected 2", bus.best_dist); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL tie_done_pulses: got %0d expected 1", nd); end
`ifdef NNF_EARLY_ABORT_EN
        n_checks++; if (lat < 1 || lat >= FIXED_LAT) begin n_fail++; $display("FAIL abort_latency: got %0d expected below %0d", lat, FIXED_LAT); end
        n_checks++; if (rd >= Q * D) begin n_fail++; $display("FAIL abort_reads: got %0d expected below %0d", rd, Q * D); end
`else
        n_checks++; if (lat != FIXED_LAT) begin n_fail++; $display("FAIL tie_latency: got %0d expected %0d", lat, FIXED_LAT); end
`endif
    endtask

    task automatic test_max();
        int lat, nd, rd;
        logic bf, bdn;
        for (int i = 0; i < Q; i++) set_sample(i, 15, 15);
        set_query(0, 0);
        do_search(1'b0, lat, nd, rd, bf, bdn);
        n_checks++; if (bus.best_addr !== 4'd0) begin n_fail++; $display("FAIL max_addr: got %0d expected 0", bus.best_addr); end
        n_checks++; if (bus.best_dist !== 10'd450) begin n_fail++; $display("FAIL max_dist: got %0d expected 450", bus.best_dist); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL max_done_pulses: got %0d expected 1", nd); end
    endtask

    task automatic test_random();
        int lat, nd, rd, ba, bd;
        logic bf, bdn;
        logic [9:0] exp_dist;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < Q; i++) set_sample(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            set_query(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            model(ba, bd);
            exp_dist = 10'(bd);
            do_search(1'b0, lat, nd, rd, bf, bdn);
            n_checks++; if (bus.best_addr !== 4'(ba)) begin n_fail++; $display("FAIL rand%0d_addr: got %0d expected %0d", it, bus.best_addr, ba); end
            n_checks++; if (bus.best_dist !== exp_dist) begin n_fail++; $display("FAIL rand%0d_dist: got %0d expected %0d", it, bus.best_dist, exp_dist); end
            n_checks++; if (nd != 1) begin n_fail++; $display("FAIL rand%0d_done_pulses: got %0d expected 1", it, nd); end
`ifndef NNF_EARLY_ABORT_EN
            n_checks++; if (lat != FIXED_LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, FIXED_LAT); end
`endif
        end
    endtask

    task automatic test_start_held();
        int lat, nd, rd;
        logic bf, bdn;
        set_sample(0, 7, 1); set_sample(1, 2, 9); set_sample(2, 8, 8); set_sample(3, 7, 2);
        set_query(7, 3);
        do_search(1'b1, lat, nd, rd, bf, bdn);
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL held_done_pulses: got %0d expected 1", nd); end
        n_checks++; if (bus.best_addr !== 4'd3) begin n_fail++; $display("FAIL held_addr: got %0d expected 3", bus.best_addr); end
        n_checks++; if (bus.best_dist !== 10'd1) begin n_fail++; $display("FAIL held_dist: got %0d expected 1", bus.best_dist); end
    endtask

    task automatic test_reset_mid();
        int nd;
        set_sample(0, 1, 1); set_sample(1, 5, 5); set_sample(2, 9, 2); set_sample(3, 3, 3);
        set_query(3, 3);
        @(negedge clk);
        for (int j = 0; j < D; j++) bus.query[j*NB +: NB] = qv[j];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.memRead !== 1'b0) begin n_fail++; $display("FAIL midrst_memRead: got %b expected 0", bus.memRead); end
        n_checks++; if (bus.best_addr !== '0) begin n_fail++; $display("FAIL midrst_best_addr: got %0d expected 0", bus.best_addr); end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) nd++;
        end
        n_checks++; if (nd != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", nd); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.query = '0;
        for (int i = 0; i < Q; i++) set_sample(i, 0, 0);
        set_query(0, 0);
        test_reset();
        test_example();
        test_tie();
        test_max();
        test_random();
        test_start_held();
        test_reset_mid();
        test_example();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
